// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 64-bit datapath ALU: the default operand width,
// the shift-amount width and the 4-bit ALU_Opcode encodings.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int REGSIZE_DEF = 64;
    localparam int SHAMT_W     = $clog2(REGSIZE_DEF);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_ORR   = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_EOR   = 4'b0011;
    localparam logic [3:0] OP_LSL   = 4'b0100;
    localparam logic [3:0] OP_LSR   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_ASR   = 4'b1000;
    localparam logic [3:0] OP_NOR   = 4'b1100;

endpackage

// File: rtl/alu_64_addsub.sv
// -----------------------------------------------------------------------------
// alu_64_addsub
// Combinational REGSIZE-bit adder/subtractor. Subtraction is A + ~B + 1, so
// carry is the ARM-style NOT-borrow (1 when A >= B unsigned).
//
// Ports:
//   a, b      : REGSIZE-bit operands
//   sub       : 1 = a - b, 0 = a + b
//   sum       : REGSIZE-bit result, modulo 2^REGSIZE
//   carry     : carry out of the MSB
//   overflow  : signed two's-complement overflow
// -----------------------------------------------------------------------------
module alu_64_addsub #(
    parameter int REGSIZE = 64
) (
    input  logic [REGSIZE-1:0] a,
    input  logic [REGSIZE-1:0] b,
    input  logic               sub,
    output logic [REGSIZE-1:0] sum,
    output logic               carry,
    output logic               overflow
);

    logic [REGSIZE-1:0] b_eff;
    logic [REGSIZE:0]   wide;

    assign b_eff = sub ? ~b : b;
    assign wide  = {1'b0, a} + {1'b0, b_eff} + {{REGSIZE{1'b0}}, sub};
    assign sum   = wide[REGSIZE-1:0];
    assign carry = wide[REGSIZE];

    // Overflow when both addends share a sign and the sum's sign differs.
    // Using the inverted B makes the subtract case fall out of the same rule.
    assign overflow = (a[REGSIZE-1] == b_eff[REGSIZE-1]) &&
                      (sum[REGSIZE-1] != a[REGSIZE-1]);

endmodule

// File: rtl/alu_64.sv
// -----------------------------------------------------------------------------
// alu_64
// Registered integer ALU for the LEGv8 single-cycle datapath. The operation
// selected by ALU_Opcode is computed combinationally and the result plus the
// Z/N/C/V flags are registered on the rising clock edge (1-cycle latency,
// one operation per cycle). Undefined opcodes give a zero result.
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high; forces ALU_Out=0, Z=1, N=C=V=0
//   A, B       : REGSIZE-bit operands (Rn, Rm/immediate)
//   ALU_Opcode : 4-bit operation select
//   ALU_Out    : registered result
//   Z, N, C, V : registered zero, negative, carry and overflow flags
// -----------------------------------------------------------------------------
module alu_64
    import alu_pkg::*;
#(
    parameter int REGSIZE = REGSIZE_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [REGSIZE-1:0] A,
    input  logic [REGSIZE-1:0] B,
    input  logic [3:0]         ALU_Opcode,
    output logic [REGSIZE-1:0] ALU_Out,
    output logic               Z,
    output logic               N,
    output logic               C,
    output logic               V
);

    localparam int SH_W = $clog2(REGSIZE);

    logic [SH_W-1:0]    shamt;
    logic [REGSIZE-1:0] as_sum;
    logic               as_carry;
    logic               as_ovf;
    logic [REGSIZE-1:0] result;
    logic               c_next;
    logic               v_next;

    // Upper bits of B are ignored for shifts.
    assign shamt = B[SH_W-1:0];

    alu_64_addsub #(
        .REGSIZE (REGSIZE)
    ) u_addsub (
        .a        (A),
        .b        (B),
        .sub      (ALU_Opcode == OP_SUB),
        .sum      (as_sum),
        .carry    (as_carry),
        .overflow (as_ovf)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        result = '0;
        c_next = 1'b0;
        v_next = 1'b0;
        case (ALU_Opcode)
            OP_AND:   result = A & B;
            OP_ORR:   result = A | B;
            OP_EOR:   result = A ^ B;
            OP_LSL:   result = A << shamt;
            OP_LSR:   result = A >> shamt;
            OP_ASR:   result = $signed(A) >>> shamt;
            OP_PASSB: result = B;
            OP_NOR:   result = ~(A | B);
            OP_ADD, OP_SUB: begin
                result = as_sum;
                c_next = as_carry;
                v_next = as_ovf;
            end
            // Undefined and X opcodes land here and keep the zero default.
            default:  result = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (reset) begin
            ALU_Out <= '0;
            Z       <= 1'b1;
            N       <= 1'b0;
            C       <= 1'b0;
            V       <= 1'b0;
        end else begin
            ALU_Out <= result;
            Z       <= (result == '0);
            N       <= result[REGSIZE-1];
            C       <= c_next;
            V       <= v_next;
        end
    end

endmodule

// File: tb/tb_alu_64.sv
// -----------------------------------------------------------------------------
// tb_alu_64
// Self-checking bench for alu_64: directed steps followed by random operations,
// each compared one cycle later against a behavioural model computed with
// plain arithmetic (multiply/divide for shifts, wide signed sums for overflow).
// -----------------------------------------------------------------------------
module tb_alu_64;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] A;
    logic [63:0] B;
    logic [3:0]  ALU_Opcode;
    logic [63:0] ALU_Out;
    logic        Z, N, C, V;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [67:0] RESET_VAL = {64'h0, 1'b1, 1'b0, 1'b0, 1'b0};

    alu_64 #(.REGSIZE(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .A          (A),
        .B          (B),
        .ALU_Opcode (ALU_Opcode),
        .ALU_Out    (ALU_Out),
        .Z          (Z),
        .N          (N),
        .C          (C),
        .V          (V)
    );

    always #5 clk = ~clk;

    // Reference: returns {result, Z, N, C, V}.
    function automatic logic [67:0] model(input logic [3:0] op,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
        logic [63:0]        r;
        logic [63:0]        p;
        logic [64:0]        wide;
        logic signed [64:0] sa, sb, s;
        logic               c, v;
        r = 64'h0;
        c = 1'b0;
        v = 1'b0;
        p = 64'd1 << b[5:0];
        sa = {a[63], a};
        sb = {b[63], b};
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[63:0];
                c = wide[64];
                s = sa + sb;
                v = (s > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (s < -65'sh0_8000_0000_0000_0000);
            end
            4'd3:  r = a ^ b;
            4'd4:  r = a * p;
            4'd5:  r = a / p;
            4'd6: begin
                r = a - b;
                c = (a >= b);
                s = sa - sb;
                v = (s > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (s < -65'sh0_8000_0000_0000_0000);
            end
            4'd7:  r = b;
            4'd8:  r = a[63] ? ~((~a) / p) : (a / p);
            4'd12: r = ~(a | b);
            default: r = 64'h0;
        endcase
        return {r, (r == 64'h0), r[63], c, v};
    endfunction

    task automatic check(input string tag, input logic [67:0] expected);
        logic [67:0] observed;
        observed = {ALU_Out, Z, N, C, V};
        n_checks++;
        assert (observed === expected) else begin
            n_fails++;
            $error("FAIL %s: observed out=%h ZNCV=%b, expected out=%h ZNCV=%b",
                   tag, observed[67:4], observed[3:0], expected[67:4], expected[3:0]);
        end
    endtask

    // Apply one operation, clock it, and compare the registered result.
    task automatic step(input string tag, input logic [3:0] op,
                        input logic [63:0] a, input logic [63:0] b);
        reset      = 1'b0;
        ALU_Opcode = op;
        A          = a;
        B          = b;
        @(posedge clk);
        #1;
        check(tag, model(op, a, b));
    endtask

    task automatic reset_step(input string tag, input logic [3:0] op,
                              input logic [63:0] a, input logic [63:0] b);
        reset      = 1'b1;
        ALU_Opcode = op;
        A          = a;
        B          = b;
        @(posedge clk);
        #1;
        check(tag, RESET_VAL);
    endtask

    initial begin
        reset = 1'b1;
        A = 64'd3;
        B = 64'd1;
        ALU_Opcode = 4'd0;
        #1;

        reset_step("reset_1", 4'd2, 64'd3, 64'd1);
        reset_step("reset_2", 4'd2, 64'd3, 64'd1);

        step("and",   4'd0, 64'd3, 64'd1);
        step("orr",   4'd1, 64'd3, 64'd1);
        step("add",   4'd2, 64'd3, 64'd1);
        step("eor",   4'd3, 64'd3, 64'd1);
        step("lsl",   4'd4, 64'd3, 64'd1);
        step("lsr",   4'd5, 64'd3, 64'd1);
        step("sub",   4'd6, 64'd3, 64'd1);
        step("passb", 4'd7, 64'd3, 64'd1);

        step("asr_0",      4'd8, 64'd3, 64'd0);
        step("asr_63",     4'd8, 64'h8000_0000_0000_0000, 64'd63);
        step("lsl_63",     4'd4, 64'h0000_0000_0000_0003, 64'd63);
        step("lsr_hi_b",   4'd5, 64'hF000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFC4);
        step("passb_zero", 4'd7, 64'd3, 64'd0);
        step("nor",        4'd12, 64'h0F0F_0000_0000_00FF, 64'h0000_0000_FFFF_0000);

        step("add_ovf",   4'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        step("add_wrap",  4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        step("sub_neg",   4'd6, 64'd1, 64'd3);
        step("sub_ovf",   4'd6, 64'h8000_0000_0000_0000, 64'd1);
        step("sub_equal", 4'd6, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);

        step("undef_f", 4'd15, 64'd5, 64'd5);
        step("undef_9", 4'd9,  64'hFFFF, 64'h1);

        for (int i = 0; i < 300; i++) begin
            logic [3:0]  op;
            logic [63:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            if ((i % 4) == 0) a[63] = ~b[63] ^ a[63];
            if ((i % 5) == 0) b = a;
            step("random", op, a, b);
        end

        step("pre_reset_add", 4'd2, 64'd3, 64'd1);
        reset_step("reset_priority", 4'd2, 64'd3, 64'd1);
        step("post_reset_add", 4'd2, 64'd3, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
